// File: rtl/oh_xor_pkg.sv
// Shared types and tree-sizing helpers for the oh_xor_reduce parity/checksum engine.
// Each tree level folds up to four lanes into one, so the depth is ceil(log4(N)).
package oh_xor_pkg;

    typedef enum logic {
        MODE_BEAT = 1'b0,
        MODE_ACC  = 1'b1
    } xor_mode_e;

    // Sideband that travels alongside the data through every tree level.
    typedef struct packed {
        logic      valid;
        xor_mode_e mode;
        logic      last;
    } beat_side_t;

    function automatic int unsigned xor_levels(input int unsigned n);
        int unsigned lv   = 1;
        int unsigned span = 4;
        while (span < n) begin
            span = span * 4;
            lv++;
        end
        return lv;
    endfunction

    // Lane count entering tree level lvl (level 0 sees all n input lanes).
    function automatic int unsigned lanes_at(input int unsigned n, input int unsigned lvl);
        int unsigned w = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            w = (w + 3) / 4;
        end
        return w;
    endfunction

endpackage

// File: rtl/oh_xor_stage.sv
// One level of the XOR reduction tree: ceil(NIN/4) four-input XOR groups, optionally
// registered together with the beat sideband; the register holds while the pipe is stalled.
module oh_xor_stage
    import oh_xor_pkg::*;
#(
    parameter int unsigned NIN  = 8,
    parameter int unsigned DW   = 8,
    parameter bit          REG  = 1'b1,
    parameter              PROP = "DEFAULT"
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         clear,
    input  logic                         stall,
    input  logic [NIN*DW-1:0]            in_data,
    input  beat_side_t                   in_side,
    output logic [((NIN+3)/4)*DW-1:0]    out_data,
    output beat_side_t                   out_side
);

    localparam int unsigned NOUT = (NIN + 3) / 4;

    logic [NOUT*4*DW-1:0] pad_data;
    logic [NOUT*DW-1:0]   xor_data;

    // Pad lanes are constant zero, so their XOR inputs simplify away.
    assign pad_data = (NOUT*4*DW)'(in_data);

    for (genvar g = 0; g < NOUT; g++) begin : g_grp
        logic [DW-1:0] a, b, c, d;

        assign a = pad_data[(4*g+0)*DW +: DW];
        assign b = pad_data[(4*g+1)*DW +: DW];
        assign c = pad_data[(4*g+2)*DW +: DW];
        assign d = pad_data[(4*g+3)*DW +: DW];

        if (PROP == "DEFAULT") begin : g_flat
            assign xor_data[g*DW +: DW] = a ^ b ^ c ^ d;
        end else begin : g_paired
            logic [DW-1:0] ab, cd;
            assign ab = a ^ b;
            assign cd = c ^ d;
            assign xor_data[g*DW +: DW] = ab ^ cd;
        end
    end

    if (REG) begin : g_reg
        logic [NOUT*DW-1:0] data_d, data_q;
        beat_side_t         side_d, side_q;

        always_comb begin
            data_d = data_q;
            side_d = side_q;
            if (clear) begin
                side_d = '0;
            end else if (!stall) begin
                data_d = xor_data;
                side_d = in_side;
            end
        end

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                data_q <= '0;
                side_q <= '0;
            end else begin
                data_q <= data_d;
                side_q <= side_d;
            end
        end

        assign out_data = data_q;
        assign out_side = side_q;
    end else begin : g_comb
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, nreset, clear, stall};
        assign out_data    = xor_data;
        assign out_side    = in_side;
    end

endmodule

// File: rtl/oh_xor_reduce.sv
// Pipelined, handshaked N-lane x DW-bit XOR reduction with per-beat and packet-accumulate modes.
// The last tree level feeds the accumulator/output register directly, so PIPE=1 gives L=LEVELS.
module oh_xor_reduce
    import oh_xor_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned DW   = 8,
    parameter int unsigned PIPE = 1,
    parameter              PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic          in_mode,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_parity
);

    localparam int unsigned LEVELS = xor_levels(N);

    logic          live_d, live_q;
    logic          stall;
    logic          accept;
    beat_side_t    src_side;
    logic [DW-1:0] fin_data;
    beat_side_t    fin_side;

    logic          out_valid_d, out_valid_q;
    logic [DW-1:0] out_data_d,  out_data_q;
    logic [DW-1:0] acc_d,       acc_q;

    // live_q keeps in_ready low during reset and for the edge that releases it.
    assign live_d   = 1'b1;
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = live_q & ~stall & ~clear;
    assign accept   = in_valid & in_ready;

    assign src_side = '{valid: accept, mode: xor_mode_e'(in_mode), last: in_last};

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned NIN  = lanes_at(N, k);
        localparam int unsigned NOUT = (NIN + 3) / 4;

        logic [NIN*DW-1:0]  sin_data;
        beat_side_t         sin_side;
        logic [NOUT*DW-1:0] sout_data;
        beat_side_t         sout_side;

        if (k == 0) begin : g_src
            assign sin_data = in_data;
            assign sin_side = src_side;
        end else begin : g_chain
            assign sin_data = g_lvl[k-1].sout_data;
            assign sin_side = g_lvl[k-1].sout_side;
        end

        oh_xor_stage #(
            .NIN  (NIN),
            .DW   (DW),
            .REG  (PIPE != 0 && (k + 1) < LEVELS),
            .PROP (PROP)
        ) u_stage (
            .clk      (clk),
            .nreset   (nreset),
            .clear    (clear),
            .stall    (stall),
            .in_data  (sin_data),
            .in_side  (sin_side),
            .out_data (sout_data),
            .out_side (sout_side)
        );
    end

    assign fin_data = g_lvl[LEVELS-1].sout_data;
    assign fin_side = g_lvl[LEVELS-1].sout_side;

    // Final stage: mode-0 beats bypass the accumulator, so an open packet survives them.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc_d       = acc_q;
        if (clear) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
        end else if (!stall) begin
            out_valid_d = 1'b0;
            if (fin_side.valid) begin
                if (fin_side.mode == MODE_BEAT) begin
                    out_valid_d = 1'b1;
                    out_data_d  = fin_data;
                end else if (fin_side.last) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q ^ fin_data;
                    acc_d       = '0;
                end else begin
                    acc_d = acc_q ^ fin_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            live_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
        end else begin
            live_q      <= live_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_parity = ^out_data_q;

endmodule

// File: tb/tb_oh_xor_reduce.sv
// Scoreboard bench for oh_xor_reduce: three instances (N=8/PIPE=1, N=8/PIPE=0, N=5/PIPE=1)
// each consume the same beat list at their own pace; results are checked in order.
module tb_oh_xor_reduce;

    typedef struct {
        logic [63:0] data;
        logic        mode;
        logic        last;
    } beat_t;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        nreset;
    logic        clear;
    logic        out_ready;
    logic        dv  [3];
    logic [63:0] dd  [3];
    logic        dm  [3];
    logic        dl  [3];
    logic        ir  [3];
    logic        ov  [3];
    logic [7:0]  od  [3];
    logic        op  [3];

    beat_t       src [$];
    exp_t        exp_q [3][$];
    int          ptr      [3];
    logic [7:0]  acc      [3];
    logic [7:0]  last_out [3];
    int          last_lat [3];
    int          n_out    [3];
    int          cyc;
    int          checks;
    int          errors;

    oh_xor_reduce #(.N(8), .DW(8), .PIPE(1), .PROP("DEFAULT")) u_p1 (
        .clk(clk), .nreset(nreset), .clear(clear), .in_valid(dv[0]), .in_ready(ir[0]),
        .in_data(dd[0]), .in_mode(dm[0]), .in_last(dl[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_parity(op[0])
    );

    oh_xor_reduce #(.N(8), .DW(8), .PIPE(0), .PROP("PAIRED")) u_p0 (
        .clk(clk), .nreset(nreset), .clear(clear), .in_valid(dv[1]), .in_ready(ir[1]),
        .in_data(dd[1]), .in_mode(dm[1]), .in_last(dl[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_parity(op[1])
    );

    oh_xor_reduce #(.N(5), .DW(8), .PIPE(1), .PROP("DEFAULT")) u_n5 (
        .clk(clk), .nreset(nreset), .clear(clear), .in_valid(dv[2]), .in_ready(ir[2]),
        .in_data(dd[2][39:0]), .in_mode(dm[2]), .in_last(dl[2]), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_parity(op[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lane_xor(input logic [63:0] d, input int unsigned n);
        logic [7:0] r = '0;
        for (int unsigned k = 0; k < n; k++) r ^= d[k*8 +: 8];
        return r;
    endfunction

    function automatic bit busy();
        for (int i = 0; i < 3; i++)
            if (ptr[i] < src.size() || exp_q[i].size() != 0 || ov[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add(input logic [63:0] d, input logic m, input logic l);
        beat_t b;
        b.data = d; b.mode = m; b.last = l;
        src.push_back(b);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 3; i++) begin
            dv[i] = ptr[i] < src.size();
            if (dv[i]) begin
                dd[i] = src[ptr[i]].data;
                dm[i] = src[ptr[i]].mode;
                dl[i] = src[ptr[i]].last;
            end else begin
                dd[i] = '0; dm[i] = 1'b0; dl[i] = 1'b0;
            end
        end
    endtask

    // One clock: sample at negedge what the next posedge will do, then drive after it.
    task automatic step();
        exp_t       e;
        beat_t      b;
        logic [7:0] x;
        @(negedge clk);
        cyc++;
        if (nreset) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("in_ready[%0d]", i), ir[i], !(ov[i] && !out_ready) && !clear);
                if (ov[i] && out_ready) begin
                    check($sformatf("result_expected[%0d]", i), exp_q[i].size() != 0, 1);
                    if (exp_q[i].size() != 0) begin
                        e = exp_q[i].pop_front();
                        check($sformatf("out_data[%0d]", i), od[i], e.val);
                        check($sformatf("out_parity[%0d]", i), op[i], ^e.val);
                        last_out[i] = od[i];
                        last_lat[i] = cyc - e.cyc;
                        n_out[i]++;
                    end
                end
                if (dv[i] && ir[i]) begin
                    b = src[ptr[i]];
                    ptr[i]++;
                    x = lane_xor(b.data, (i == 2) ? 5 : 8);
                    if (!b.mode) begin
                        e.val = x; e.cyc = cyc; exp_q[i].push_back(e);
                    end else if (b.last) begin
                        e.val = acc[i] ^ x; e.cyc = cyc; exp_q[i].push_back(e);
                        acc[i] = '0;
                    end else begin
                        acc[i] ^= x;
                    end
                end
                if (clear) begin
                    exp_q[i].delete();
                    acc[i] = '0;
                end
            end
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check("drain_complete", busy(), 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        drive_inputs();
        @(posedge clk);
        #1;
    endtask

    int         n0 [3];
    logic [7:0] exp_ff [3] = '{8'hFF, 8'hFF, 8'h1F};
    logic [7:0] exp_a5 [3] = '{8'h00, 8'h00, 8'hA5};
    int         exp_lat[3] = '{2, 1, 2};

    initial begin
        checks = 0; errors = 0; cyc = 0;
        nreset = 1'b0; clear = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ptr[i] = 0; acc[i] = '0; n_out[i] = 0; last_out[i] = '0; last_lat[i] = 0;
            dv[i] = 1'b1; dd[i] = {$urandom, $urandom}; dm[i] = 1'b0; dl[i] = 1'b0;
        end

        // Reset with in_valid held high
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_in_ready[%0d]", i), ir[i], 0);
            check($sformatf("rst_out_valid[%0d]", i), ov[i], 0);
            check($sformatf("rst_out_data[%0d]", i), od[i], 8'h00);
        end
        release_reset();
        for (int i = 0; i < 3; i++) check($sformatf("post_rst_in_ready[%0d]", i), ir[i], 1);

        // Mode 0: one-hot lanes, then all 0xA5; latency measured on the first beat
        add(64'h8040201008040201, 1'b0, 1'b0);
        drive_inputs();
        drain(20);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("onehot_data[%0d]", i), last_out[i], exp_ff[i]);
            check($sformatf("latency[%0d]", i), last_lat[i], exp_lat[i]);
        end
        add({8{8'hA5}}, 1'b0, 1'b0);
        drive_inputs();
        drain(20);
        for (int i = 0; i < 3; i++) check($sformatf("a5_data[%0d]", i), last_out[i], exp_a5[i]);

        // Mode 1: three-beat packet then a single-beat packet
        for (int i = 0; i < 3; i++) n0[i] = n_out[i];
        add(64'h11, 1'b1, 1'b0);
        add(64'h22, 1'b1, 1'b0);
        add(64'h44, 1'b1, 1'b1);
        drive_inputs();
        drain(20);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pkt_count[%0d]", i), n_out[i] - n0[i], 1);
            check($sformatf("pkt_data[%0d]", i), last_out[i], 8'h77);
        end
        add(64'h01, 1'b1, 1'b1);
        drive_inputs();
        drain(20);
        for (int i = 0; i < 3; i++) check($sformatf("single_pkt[%0d]", i), last_out[i], 8'h01);

        // Backpressure: 10 back-to-back beats, out_ready low for cycles 3..7
        for (int i = 0; i < 3; i++) n0[i] = n_out[i];
        for (int k = 0; k < 10; k++) add({$urandom, $urandom}, 1'b0, 1'b0);
        drive_inputs();
        for (int c = 0; c < 40 && busy(); c++) begin
            out_ready = !(c >= 3 && c <= 7);
            if (c == 5) begin
                #1;
                for (int i = 0; i < 3; i++) check($sformatf("stall_in_ready[%0d]", i), ir[i], 0);
            end
            step();
        end
        out_ready = 1'b1;
        drain(20);
        for (int i = 0; i < 3; i++) check($sformatf("bp_count[%0d]", i), n_out[i] - n0[i], 10);

        // clear mid-packet: the beat offered alongside clear must wait
        add(64'h0F, 1'b1, 1'b0);
        add(64'hF0, 1'b1, 1'b0);
        drive_inputs();
        drain(20);
        for (int i = 0; i < 3; i++) n0[i] = n_out[i];
        add(64'h03, 1'b1, 1'b1);
        clear = 1'b1;
        drive_inputs();
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("clear_in_ready[%0d]", i), ir[i], 0);
        step();
        clear = 1'b0;
        drain(20);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("clear_count[%0d]", i), n_out[i] - n0[i], 1);
            check($sformatf("clear_data[%0d]", i), last_out[i], 8'h03);
        end

        // Async reset with results in flight
        for (int k = 0; k < 20; k++) add({$urandom, $urandom}, 1'b0, 1'b0);
        drive_inputs();
        repeat (5) step();
        #2;
        check("pre_reset_out_valid", ov[0], 1);
        nreset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async_out_valid[%0d]", i), ov[i], 0);
            check($sformatf("async_out_data[%0d]", i), od[i], 8'h00);
        end
        src.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete(); ptr[i] = 0; acc[i] = '0; n_out[i] = 0;
        end
        drive_inputs();
        release_reset();
        repeat (8) step();
        for (int i = 0; i < 3; i++) check($sformatf("no_stale[%0d]", i), n_out[i], 0);

        // Random mixed traffic with backpressure and occasional clear
        for (int k = 0; k < 300; k++)
            add({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
        drive_inputs();
        for (int c = 0; c < 4000 && busy(); c++) begin
            out_ready = $urandom_range(0, 3) != 0;
            clear     = $urandom_range(0, 40) == 0;
            step();
        end
        clear = 1'b0;
        out_ready = 1'b1;
        drain(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
